random_range_unit: RTL and testbench
====================================

# random_range_unit

Downstream consumer of the 32-bit LFSR random word. On a request from the CPU/game logic, it snapshots the current random value and reduces it to the range [0, LIMIT−1] by sequential restoring remainder. It returns the result through a fixed-latency request/done handshake, so game code gets bounded random numbers for spawn positions, directions and similar uses without a software modulo.

## Interface
- WIDTH, 32, width of random word, LIMIT and RESULT
- CLK  in  1  single clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- RANDOM_IN  in  WIDTH  free-running random word from the generator
- REQ  in  1  request; level-sampled only while BUSY=0
- LIMIT  in  WIDTH  exclusive upper bound; sampled with REQ
- BUSY  out  1  high in CALC and DONE states
- DONE  out  1  one-cycle pulse when RESULT/ERR are valid
- RESULT  out  WIDTH  RANDOM_IN mod LIMIT; held until the next accepted REQ
- ERR  out  1  LIMIT was 0; held like RESULT

## Operation
- States: IDLE, CALC, FIN. Encoding 2 bits: IDLE=0, CALC=1, FIN=2.
- IDLE with REQ=1 (accept):
  - latch RANDOM_IN into dividend shift register and LIMIT into divisor register
  - clear remainder (WIDTH+1 bits), load bit counter = WIDTH−1
  - if LIMIT=0: set ERR=1 and RESULT=0, go to FIN
  - else: set ERR=0, go to CALC
- CALC, each cycle:
  - rem ← {rem[WIDTH−1:0], dividend MSB}, then shift the dividend left
  - if rem ≥ {0,divisor}: rem ← rem − divisor
  - when counter = 0: RESULT ← rem[WIDTH−1:0] and go to FIN; else decrement the counter
- FIN: DONE=1 for exactly this cycle; next state IDLE.
- REQ while BUSY=1 is ignored (not queued). The requester must re-assert REQ after DONE.
- RANDOM_IN and LIMIT changes after acceptance have no effect.
- The remainder is WIDTH+1 bits, so LIMIT ≥ 2^(WIDTH−1) never overflows. The final remainder is always < LIMIT.
- The result for LIMIT=1 is always 0, computed through the normal path.
- The result is not made uniform; modulo bias is accepted.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, RESULT=0, ERR=0; internal registers 0.
- Normal request, REQ accepted at edge k:
  - BUSY=1 from k
  - CALC occupies edges k+1 … k+WIDTH
  - FIN is entered at edge k+WIDTH, so DONE is high in the cycle after edge k+WIDTH (33rd cycle for WIDTH=32)
  - IDLE at edge k+WIDTH+1
- LIMIT=0: FIN is entered at edge k, so DONE is high in the next cycle; latency 1.
- Earliest back-to-back acceptance: the edge at which the state returns to IDLE+1, i.e. REQ is sampled in the first IDLE cycle.
- RESULT and ERR update no later than the edge entering FIN. They are stable while DONE=1 and thereafter.
- RST=1 at any edge, including mid-CALC or in FIN:
  - all outputs and state return to reset values at that edge
  - the in-flight computation is discarded and no DONE pulse is produced

## Structure
- Shared package `rand_pkg`: state encoding constants (IDLE/CALC/FIN) and WIDTH default.
- Sub-module `mod_step`: combinational single restoring step. Inputs rem_in, next bit, divisor; output rem_out. Instantiated once in the top FSM.
- Top module: FSM, counter, dividend/divisor/remainder registers, output registers.

## Test plan
- RANDOM_IN=100, LIMIT=7, pulse REQ → DONE pulse 33 cycles later; RESULT=2, ERR=0.
- RANDOM_IN=0xFFFFFFFF, LIMIT=10 → RESULT=5. Same input with LIMIT=0x80000001 → RESULT=0x7FFFFFFE, exercising the MSB/overflow path.
- LIMIT=0 → DONE on the cycle after acceptance, ERR=1, RESULT=0. A following request with LIMIT=3, RANDOM_IN=8 → ERR=0, RESULT=2.
- Hold REQ high continuously and change RANDOM_IN/LIMIT every cycle during CALC → RESULT matches the values latched at acceptance. Exactly one DONE per 34-cycle window, with the next acceptance in the IDLE cycle.
- Assert RST on the 10th CALC cycle → BUSY=0, RESULT=0, no DONE. Next request (RANDOM_IN=50, LIMIT=8) → RESULT=2.
- Connect to the live generator and issue 1000 requests with LIMIT=6 → every RESULT < 6, and every residue 0–5 is observed.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the bounded random number unit: default word
// width and the controller state encoding.
package rand_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_step.sv
// One restoring-remainder step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits. The partial
// remainder carries one extra bit so divisors with the MSB set cannot
// overflow the shift.
module mod_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out
);

    logic [WIDTH+1:0] shifted;
    logic             fits;

    assign shifted = {rem_in, bit_in};
    assign fits    = (shifted >= {2'b00, divisor});
    assign rem_out = fits ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];

endmodule

// File: rtl/random_range_unit.sv
// Bounded random number unit: on request, snapshots the random word and
// reduces it modulo LIMIT with one restoring step per cycle, then pulses
// done_o for one cycle with the result and error flag held afterwards.
module random_range_unit
    import rand_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] random_in_i,
    input  logic             req_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    mod_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .bit_in (dividend_q[WIDTH-1]),
        .divisor(divisor_q),
        .rem_out(rem_d)
    );

    // Controller: accepts requests in IDLE, iterates the remainder in CALC,
    // and announces the held result with a single-cycle pulse in FIN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        dividend_q <= random_in_i;
                        divisor_q  <= limit_i;
                        rem_q      <= '0;
                        cnt_q      <= CNT_LAST;
                        busy_q     <= 1'b1;
                        if (limit_i == '0) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= FIN;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q      <= rem_d;
                    dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        result_q <= rem_d[WIDTH-1:0];
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_random_range_unit.sv
// Self-checking bench for random_range_unit: directed requests push their
// expected result, error flag and DONE cycle into a scoreboard that a
// separate monitor drains whenever DONE is seen.
module tb_random_range_unit;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          doneCycle;
        logic [31:0] lim;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] randomIn;
    logic [31:0] liveRand;
    logic        useLive;
    logic [31:0] dutRandom;
    logic        req;
    logic [31:0] limit;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    exp_t sb[$];
    int   cycle;
    int   total;
    int   bad;
    bit   seen [6];

    assign dutRandom = useLive ? liveRand : randomIn;

    random_range_unit #(
        .WIDTH(32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .random_in_i(dutRandom),
        .req_i      (req),
        .limit_i    (limit),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .err_o      (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to timestamp acceptance and DONE.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Stand-in for the live LFSR: an xorshift generator advancing every edge.
    always @(posedge clk) begin
        logic [31:0] x;
        x = liveRand;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        liveRand <= x;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    // Waits for the unit to be idle, then issues one request on the next edge.
    task automatic applyStimulus(input logic [31:0] rnd, input logic [31:0] lim,
                                 input logic [31:0] expRes, input logic expErr,
                                 input bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checkOutput("idle_timeout", 32'(busy), 32'd0);
            return;
        end
        randomIn = rnd;
        limit    = lim;
        req      = 1'b1;
        if (push) begin
            if (useLive) begin
                e.res = liveRand % lim;
                e.err = 1'b0;
            end else begin
                e.res = expRes;
                e.err = expErr;
            end
            e.lim       = lim;
            e.doneCycle = cycle + 1 + ((lim == 32'd0) ? 0 : 32);
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("err", 32'(err), 32'(e.err));
                checkOutput("done_cycle", 32'(cycle), 32'(e.doneCycle));
                if (e.lim == 32'd6 && result < 32'd6) seen[int'(result)] = 1'b1;
            end
        end
    end

    initial begin
        int   accepts;
        int   lastK;
        int   t;
        exp_t e;
        total    = 0;
        bad      = 0;
        cycle    = 0;
        liveRand = 32'h2545_F491;
        useLive  = 1'b0;
        rst      = 1'b1;
        req      = 1'b0;
        randomIn = 32'd0;
        limit    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);

        // Basic and wide-operand reductions.
        applyStimulus(32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 1'b1);
        applyStimulus(32'd12345, 32'd1, 32'd0, 1'b0, 1'b1);

        // Zero limit followed immediately by a normal request.
        applyStimulus(32'd999, 32'd0, 32'd0, 1'b1, 1'b1);
        applyStimulus(32'd8, 32'd3, 32'd2, 1'b0, 1'b1);

        // REQ held high with inputs changing every cycle.
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput("hold_start_idle", 32'(busy), 32'd0);
        req     = 1'b1;
        accepts = 0;
        lastK   = -1;
        for (int i = 0; i < 102; i++) begin
            randomIn = 32'h1234_0000 + 32'(i) * 32'd977;
            limit    = 32'd5 + 32'(i);
            if (!busy) begin
                e.res       = randomIn % limit;
                e.err       = 1'b0;
                e.lim       = limit;
                e.doneCycle = cycle + 1 + 32;
                sb.push_back(e);
                if (lastK >= 0) checkOutput("hold_spacing", 32'(cycle + 1 - lastK), 32'd34);
                lastK = cycle + 1;
                accepts++;
            end
            @(negedge clk);
        end
        req = 1'b0;
        checkOutput("hold_accepts", 32'(accepts), 32'd3);

        // Reset in the 10th CALC cycle discards the computation.
        applyStimulus(32'd7777, 32'd13, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midcalc_busy", 32'(busy), 32'd0);
        checkOutput("midcalc_result", result, 32'd0);
        checkOutput("midcalc_err", 32'(err), 32'd0);
        checkOutput("midcalc_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus(32'd50, 32'd8, 32'd2, 1'b0, 1'b1);

        // Live generator with LIMIT=6.
        useLive = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(32'd0, 32'd6, 32'd0, 1'b0, 1'b1);
        end
        useLive = 1'b0;

        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        for (int r = 0; r < 6; r++) begin
            checkOutput($sformatf("residue_%0d_seen", r), 32'(seen[r]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
